// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command byte transmitter driving open-drain pull-low enables
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int BIT_TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int WW = $clog2(BIT_TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE} state_t;
  state_t state, state_n;
  logic clk_prev, fall, act, fin, to, acc, d_low, ok;
  logic [IW-1:0] cnt;
  logic [WW-1:0] wd;
  logic [3:0] idx;
  logic [8:0] sh;
  assign fall = clk_prev && !ps2_clk_in;
  assign act = state inside {SEND, ACK, WAIT_IDLE};
  assign fin = state == WAIT_IDLE && ps2_clk_in && ps2_data_in;
  assign to = act && !fall && wd == WW'(BIT_TIMEOUT_CYCLES - 1);
  assign tx_ready = state == IDLE || fin || to;
  assign acc = tx_valid && tx_ready;
  // next state and bus/handshake outputs; completion and acceptance override the frame sequencing
  always_comb begin
    state_n = state;
    case (state)
      INHIBIT: state_n = cnt == IW'(INHIBIT_CYCLES - 1) ? REQ : INHIBIT;
      REQ:     state_n = SEND;
      SEND:    state_n = fall && idx == 4'd9 ? ACK : SEND;
      ACK:     state_n = fall ? WAIT_IDLE : ACK;
      default: ;
    endcase
    if (fin || to) state_n = IDLE;
    if (acc) state_n = INHIBIT;
    tx_done = fin && ok;
    tx_error = fin ? !ok : to;
    ps2_clk_drive_low = state == INHIBIT || state == REQ;
    ps2_data_drive_low = d_low && !to;
  end
  // state register; reset releases both lines immediately
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // edge history, counters, shift register and data-line driver
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      clk_prev <= 1'b1;
      d_low <= 1'b0;
      ok <= 1'b0;
      cnt <= '0;
      wd <= '0;
      idx <= '0;
      sh <= '0;
    end else begin
      clk_prev <= ps2_clk_in;
      cnt <= state == INHIBIT ? cnt + 1'b1 : '0;
      wd <= act && !fall ? wd + 1'b1 : '0;
      idx <= state == SEND ? idx + {3'b0, fall} : '0;
      if (acc) sh <= {~^tx_data, tx_data};
      else if (state == SEND && fall) sh <= {1'b1, sh[8:1]};
      if (state_n == REQ) d_low <= 1'b1;
      else if (state_n == IDLE || state_n == INHIBIT) d_low <= 1'b0;
      else if (state == SEND && fall) d_low <= idx != 4'd9 && !sh[0];
      if (state == ACK && fall) ok <= !ps2_data_in;
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: PS/2 device model driving ps2_host_tx with table, random and corner-case frames
module tb_ps2_host_tx;
  logic clk = 1'b0, rst_n = 1'b0, tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic tx_ready, tx_done, tx_error, ps2_clk_drive_low, ps2_data_drive_low;
  logic ps2_clk_in, ps2_data_in;
  logic dev_clk_low = 1'b0, dev_data_low = 1'b0, err_drv = 1'b0;
  int pass_cnt = 0, total = 0, cyc = 0, done_cnt = 0, err_cnt = 0, err_cyc = 0, fall_cyc = 0;
  string tag = "reset";
  typedef struct { logic [7:0] d; bit ack; bit done; bit err; } vec_t;
  vec_t tbl [5];
  assign ps2_clk_in = !(ps2_clk_drive_low || dev_clk_low);
  assign ps2_data_in = !(ps2_data_drive_low || dev_data_low);
  always #5 clk = ~clk;
  ps2_host_tx #(.INHIBIT_CYCLES(8), .BIT_TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_done(tx_done), .tx_error(tx_error), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_drive_low(ps2_clk_drive_low), .ps2_data_drive_low(ps2_data_drive_low)
  );
  task automatic chk(input string nm, input int a, input int e);
    total++;
    if (a == e) pass_cnt++;
    else $display("FAIL %s/%s: got %0h expected %0h", tag, nm, a, e);
  endtask
  task automatic step();
    #1;
    if (tx_done) done_cnt++;
    if (tx_error) begin
      err_cnt++;
      err_cyc = cyc;
      err_drv = ps2_clk_drive_low || ps2_data_drive_low;
    end
    cyc++;
    @(negedge clk);
    #1;
  endtask
  function automatic logic [10:0] exp_frame(input logic [7:0] d);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    return {1'b1, ones % 2 == 0, d, 1'b0};
  endfunction
  task automatic wait_end(input int d0, input int e0);
    int n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 300) begin
      step();
      n++;
    end
    chk("end_wait", int'(n < 300), 1);
  endtask
  task automatic dev_frame(input int nf, input bit ack, output logic [10:0] rx);
    int n = 0, inh = 0, req = 0;
    rx = '0;
    while (!ps2_clk_drive_low && n < 50) begin step(); n++; end
    while (ps2_clk_drive_low && !ps2_data_drive_low && inh < 100) begin inh++; step(); end
    while (ps2_clk_drive_low && ps2_data_drive_low && req < 10) begin req++; step(); end
    chk("inhibit_len", inh, 8);
    chk("req_len", req, 1);
    rx[0] = ps2_data_in;
    repeat (10) step();
    for (int k = 1; k <= nf; k++) begin
      dev_clk_low = 1'b1;
      fall_cyc = cyc;
      repeat (10) step();
      dev_clk_low = 1'b0;
      if (k <= 10) rx[4'(k)] = ps2_data_in;
      repeat (5) step();
      if (k == 10) dev_data_low = ack;
      repeat (5) step();
    end
    dev_data_low = 1'b0;
  endtask
  task automatic run_frame(input logic [7:0] d, input bit ack, input int e_done, input int e_err);
    logic [10:0] rx, ef;
    int d0, e0;
    ef = exp_frame(d);
    tx_data = d;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    chk("latency", int'(ps2_clk_drive_low), 1);
    chk("ready_drop", int'(tx_ready), 0);
    d0 = done_cnt;
    e0 = err_cnt;
    dev_frame(11, ack, rx);
    chk("frame", int'(rx), int'(ef));
    chk("parity", int'(rx[9]), int'(ef[9]));
    wait_end(d0, e0);
    chk("done", done_cnt - d0, e_done);
    chk("error", err_cnt - e0, e_err);
    chk("ready_back", int'(tx_ready), 1);
  endtask
  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [10:0] rx, rx2;
    logic [7:0] d;
    bit ack;
    int d0, e0;
    tbl[0] = '{8'hED, 1'b1, 1'b1, 1'b0};
    tbl[1] = '{8'h01, 1'b1, 1'b1, 1'b0};
    tbl[2] = '{8'h00, 1'b1, 1'b1, 1'b0};
    tbl[3] = '{8'hFF, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{8'h80, 1'b1, 1'b1, 1'b0};
    repeat (3) @(negedge clk);
    #1;
    chk("ready", int'(tx_ready), 1);
    chk("done", int'(tx_done), 0);
    chk("error", int'(tx_error), 0);
    chk("drives", int'({ps2_clk_drive_low, ps2_data_drive_low}), 0);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      tag = $sformatf("tbl%0d", i);
      run_frame(tbl[i].d, tbl[i].ack, int'(tbl[i].done), int'(tbl[i].err));
    end
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      ack = $urandom_range(0, 3) != 0;
      tag = $sformatf("rnd%0d_%02h", i, d);
      run_frame(d, ack, int'(ack), int'(!ack));
    end
    tag = "stall";
    tx_data = 8'h5A;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    d0 = done_cnt;
    e0 = err_cnt;
    dev_frame(4, 1'b1, rx);
    wait_end(d0, e0);
    chk("error", err_cnt - e0, 1);
    chk("done", done_cnt - d0, 0);
    chk("timeout_gap", err_cyc - fall_cyc, 64);
    chk("drive_at_err", int'(err_drv), 0);
    chk("ready", int'(tx_ready), 1);
    chk("drives", int'({ps2_clk_drive_low, ps2_data_drive_low}), 0);
    tag = "reset_mid";
    tx_data = 8'h00;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    dev_frame(6, 1'b1, rx);
    chk("pre_drive", int'(ps2_data_drive_low), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_data", int'(ps2_data_drive_low), 0);
    chk("async_clk", int'(ps2_clk_drive_low), 0);
    chk("async_ready", int'(tx_ready), 1);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("ready_after", int'(tx_ready), 1);
    run_frame(8'hFF, 1'b1, 1, 0);
    tag = "b2b";
    tx_data = 8'hA5;
    tx_valid = 1'b1;
    step();
    chk("latency", int'(ps2_clk_drive_low), 1);
    d0 = done_cnt;
    e0 = err_cnt;
    fork
      dev_frame(11, 1'b1, rx);
      begin
        repeat (60) @(negedge clk);
        #1 tx_data = 8'h3C;
      end
    join
    wait_end(d0, e0);
    chk("frame1", int'(rx), int'(exp_frame(8'hA5)));
    chk("done1", done_cnt - d0, 1);
    chk("accept2", int'(ps2_clk_drive_low), 1);
    tx_valid = 1'b0;
    d0 = done_cnt;
    e0 = err_cnt;
    dev_frame(11, 1'b1, rx2);
    wait_end(d0, e0);
    chk("frame2", int'(rx2), int'(exp_frame(8'h3C)));
    chk("done2", done_cnt - d0, 1);
    chk("error2", err_cnt - e0, 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter: sends one command byte (e.g. LED set 0xED, reset 0xFF) to the keyboard over the open-drain PS/2 clock/data pair.
- Input side of the PS/2 link: takes the already synchronized, debounced PS/2 clock and data levels from the existing line-conditioning path.
- Output side: drives the bus only through pull-low enables; the top level builds the tristate pads.
- Runs on the system clock and reports done or error per byte.

Parameters:
- INHIBIT_CYCLES, 5000, clk cycles clock line is held low before the start bit (≥100 µs at 50 MHz).
- BIT_TIMEOUT_CYCLES, 100000, max clk cycles allowed between consecutive device falling edges, and from clock release to the first falling edge (2 ms at 50 MHz).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- tx_data  in  8  byte to send
- tx_valid  in  1  request; byte accepted when tx_valid & tx_ready
- tx_ready  out  1  idle, can accept a byte
- tx_done  out  1  one-cycle pulse: device acknowledged
- tx_error  out  1  one-cycle pulse: no ack or timeout
- ps2_clk_in  in  1  conditioned PS/2 clock level
- ps2_data_in  in  1  conditioned PS/2 data level
- ps2_clk_drive_low  out  1  1 = pull PS/2 clock low
- ps2_data_drive_low  out  1  1 = pull PS/2 data low

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - Outputs: tx_ready=1, tx_done=0, tx_error=0, both drive_low=0 (lines released at once, including mid-frame).
  - Edge register = 1; counters = 0.
- Falling-edge detect: clk_prev registered each cycle; fall = clk_prev & ~ps2_clk_in. Detection only; no resynchronisation.
- Frame: 11 bits = start 0, data LSB first, odd parity (parity = ~^tx_data), stop 1, then device ack 0.
- IDLE:
  - tx_ready=1.
  - On tx_valid, latch tx_data and parity into a shift register and go to INHIBIT.
  - tx_ready drops the cycle after acceptance.
- INHIBIT:
  - clk_drive_low=1.
  - Count INHIBIT_CYCLES cycles, then go to REQ.
- REQ (1 cycle):
  - clk_drive_low=1 and data_drive_low=1 (start bit).
  - Next cycle clk_drive_low=0; go to SEND with bit index 0; watchdog cleared.
- SEND:
  - On each fall, present the next bit: data_drive_low = ~bit; index increments.
  - Order: index 0..7 data, 8 parity, 9 stop (data released).
  - After the stop bit is presented, go to ACK.
  - Data output only changes on fall.
- ACK:
  - On the next fall, sample ps2_data_in.
  - 0 → go to WAIT_IDLE with ok flag set.
  - 1 → go to WAIT_IDLE with error flag set.
- WAIT_IDLE:
  - Wait until ps2_clk_in=1 and ps2_data_in=1.
  - Then pulse tx_done (ok) or tx_error (error) for one cycle and return to IDLE; tx_ready=1 in that same cycle.
- Watchdog (SEND, ACK, WAIT_IDLE):
  - Counts clk cycles and clears on every fall.
  - On reaching BIT_TIMEOUT_CYCLES: release both lines, pulse tx_error, go to IDLE.
- Simultaneous events:
  - Timeout and fall in the same cycle: the fall wins and the watchdog clears.
  - tx_valid while not IDLE: ignored, not queued.
  - tx_valid in the cycle tx_done/tx_error pulses: accepted, since tx_ready=1.
- Widths:
  - Counter widths: $clog2(param+1).
  - Bit index: 4 bits, no wrap; states exit explicitly.
- Latency: tx_valid to clock pulled low is 1 cycle; tx_done to next acceptance is 0 cycles.

Test Plan (bench uses INHIBIT_CYCLES=8, BIT_TIMEOUT_CYCLES=64; device model clocks with a 20-cycle period, samples data on rising edges, acks with 0):
- Send 0xED → clock held low exactly 8 cycles; start 0; bits sampled 1,0,1,1,0,1,1,1; parity 1; stop 1; tx_done pulses once; tx_error stays 0.
- Send 0x01 → parity bit 0; 0x00 → parity bit 1; device model reports no frame error.
- Device model omits ack (data high on 11th fall) → tx_error pulses after lines idle; tx_done stays 0; tx_ready returns 1.
- Device stops clocking after 4 bits → 64 cycles after the last fall: tx_error pulses, both drive_low=0, state IDLE.
- rst_n low during SEND bit 5 → both drive_low=0 asynchronously (before the next clk edge); after release tx_ready=1 and a new 0xFF send completes.
- tx_valid held high across a frame with tx_data changed mid-frame → the latched byte is sent unchanged; a second byte is accepted in the tx_done cycle.
